// File: rtl/wb_pkg.sv
// Writeback-stage shared types: wbsel/ldtype encodings and the WB register bundle.
// Sub-word load extraction is enabled by defining WB_LOAD_EXT_EN.
package wb_pkg;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LOAD = 2'b01,
    WB_LINK = 2'b10,
    WB_ALT  = 2'b11
  } wbsel_e;

  typedef enum logic [2:0] {
    LD_W  = 3'b000,
    LD_B  = 3'b001,
    LD_BU = 3'b010,
    LD_H  = 3'b011,
    LD_HU = 3'b100
  } ldtype_e;

  typedef struct packed {
    logic        valid;
    logic        regwrite;
    logic [4:0]  rd;
    wbsel_e      wbsel;
`ifdef WB_LOAD_EXT_EN
    ldtype_e     ldtype;
`endif
    logic [31:0] alu;
    logic [31:0] ldata;
    logic [31:0] pc4;
  } wb_reg_t;

endpackage

// File: rtl/wb_load_align.sv
// Little-endian load lane extraction with sign/zero extension.
// Undefined ldtype codes pass the raw word; misalignment is not checked.
module wb_load_align
  import wb_pkg::*;
(
  input  ldtype_e     ldtype,
  input  logic [1:0]  addr,
  input  logic [31:0] word,
  output logic [31:0] data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = word[7:0];
    case (addr)
      2'd1:    lane_b = word[15:8];
      2'd2:    lane_b = word[23:16];
      2'd3:    lane_b = word[31:24];
      default: lane_b = word[7:0];
    endcase
  end

  assign lane_h = addr[1] ? word[31:16] : word[15:0];

  always_comb begin
    data = word;
    case (ldtype)
      LD_B:    data = {{24{lane_b[7]}}, lane_b};
      LD_BU:   data = {24'h0, lane_b};
      LD_H:    data = {{16{lane_h[15]}}, lane_h};
      LD_HU:   data = {16'h0, lane_h};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: WB register, late-result queue, register-file write arbiter.
// Define WB_LOAD_EXT_EN to enable sub-word load extraction.
module wb_stage
  import wb_pkg::*;
#(
  parameter int LQ_DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        stall,
  input  logic                        flush,
  input  logic                        mem_valid,
  input  logic                        mem_regwrite,
  input  logic [4:0]                  mem_rd,
  input  logic [1:0]                  mem_wbsel,
  input  logic [2:0]                  mem_ldtype,
  input  logic [31:0]                 mem_alu,
  input  logic [31:0]                 mem_ldata,
  input  logic [31:0]                 mem_pc4,
  input  logic                        late_valid,
  output logic                        late_ready,
  input  logic [4:0]                  late_rd,
  input  logic [31:0]                 late_data,
  output logic                        rf_wr,
  output logic [4:0]                  rf_addr,
  output logic [31:0]                 rf_data,
  output logic [$clog2(LQ_DEPTH+1)-1:0] lq_count
);

  localparam int CW = $clog2(LQ_DEPTH + 1);
  localparam int PW = $clog2(LQ_DEPTH);
  localparam logic [CW-1:0] FULL = CW'(LQ_DEPTH);

  wb_reg_t wb_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_q <= '0;
    end else if (flush) begin
      wb_q.valid <= 1'b0;
    end else if (!stall) begin
      wb_q.valid    <= mem_valid;
      wb_q.regwrite <= mem_regwrite;
      wb_q.rd       <= mem_rd;
      wb_q.wbsel    <= wbsel_e'(mem_wbsel);
`ifdef WB_LOAD_EXT_EN
      wb_q.ldtype   <= ldtype_e'(mem_ldtype);
`endif
      wb_q.alu      <= mem_alu;
      wb_q.ldata    <= mem_ldata;
      wb_q.pc4      <= mem_pc4;
    end
  end

  logic [31:0] ld_val;

`ifdef WB_LOAD_EXT_EN
  wb_load_align u_align (
    .ldtype (wb_q.ldtype),
    .addr   (wb_q.alu[1:0]),
    .word   (wb_q.ldata),
    .data   (ld_val)
  );
`else
  wire ldtype_unused = ^mem_ldtype;
  assign ld_val = wb_q.ldata;
`endif

  logic [31:0] wb_val;

  always_comb begin
    wb_val = wb_q.alu;
    case (wb_q.wbsel)
      WB_LOAD: wb_val = ld_val;
      WB_LINK: wb_val = wb_q.pc4;
      default: wb_val = wb_q.alu;
    endcase
  end

  logic pw;
  assign pw = wb_q.valid & wb_q.regwrite & (wb_q.rd != 5'd0);

  logic [4:0]    lq_rd   [LQ_DEPTH];
  logic [31:0]   lq_data [LQ_DEPTH];
  logic [PW-1:0] wptr_q;
  logic [PW-1:0] rptr_q;
  logic [CW-1:0] cnt_q;
  logic          lq_nempty;
  logic          push;
  logic          pop;

  assign lq_nempty  = (cnt_q != '0);
  assign late_ready = (cnt_q < FULL);
  // rd=0 pushes are handshaked but never stored
  assign push = late_valid & late_ready & (late_rd != 5'd0);
  assign pop  = ~pw & lq_nempty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < LQ_DEPTH; i++) begin
        lq_rd[i]   <= '0;
        lq_data[i] <= '0;
      end
    end else begin
      if (push) begin
        lq_rd[wptr_q]   <= late_rd;
        lq_data[wptr_q] <= late_data;
        wptr_q          <= wptr_q + PW'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_comb begin
    rf_wr   = 1'b0;
    rf_addr = 5'd0;
    rf_data = 32'd0;
    if (pw) begin
      rf_wr   = 1'b1;
      rf_addr = wb_q.rd;
      rf_data = wb_val;
    end else if (lq_nempty) begin
      rf_wr   = 1'b1;
      rf_addr = lq_rd[rptr_q];
      rf_data = lq_data[rptr_q];
    end
  end

  assign lq_count = cnt_q;

endmodule
